// File: rtl/pspin_hostmem_dma_pkg.sv
// Shared types and AXI constants for the PsPIN host-memory DMA adapter (rd and wr halves).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pspin_hostmem_dma_pkg;

  // Adapter FSM: accept AW, collect W, issue descriptor, wait status, return response.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_DESC = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } dma_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR      = 2'b01;

endpackage

// File: rtl/pspin_hostmem_dma_seg_ram.sv
// One RAM segment of the burst buffer: write port from AXI W, read port for the DMA engine.
// Latency: read response one cycle after the command handshake.
// Backpressure: response held until rd_resp_ready; rd_cmd_ready = !rd_resp_valid || rd_resp_ready.
module pspin_hostmem_dma_seg_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_row,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_cmd_addr,
  input  logic                     rd_cmd_valid,
  output logic                     rd_cmd_ready,
  output logic [DATA_W-1:0]        rd_resp_data,
  output logic                     rd_resp_valid,
  input  logic                     rd_resp_ready
);

  localparam int ROW_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              en_q, en_d;
  logic              resp_vld_q, resp_vld_d;
  logic [DATA_W-1:0] resp_dat_q, resp_dat_d;
  logic [ROW_W-1:0]  rd_row;
  logic              rd_fire;
  logic              unused_addr;

  // Only the low row bits address the buffer; the rest of the DMA RAM address is don't-care.
  assign rd_row      = rd_cmd_addr[ROW_W-1:0];
  assign unused_addr = ^rd_cmd_addr[ADDR_W-1:ROW_W];

  // en_q keeps the command port closed while reset is asserted.
  assign rd_cmd_ready  = en_q && (!resp_vld_q || rd_resp_ready);
  assign rd_fire       = rd_cmd_valid && rd_cmd_ready;
  assign rd_resp_valid = resp_vld_q;
  assign rd_resp_data  = resp_dat_q;

  // Buffer storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Next response: load on command, clear once consumed, otherwise hold.
  always_comb begin
    en_d       = 1'b1;
    resp_vld_d = resp_vld_q;
    resp_dat_d = resp_dat_q;
    if (rd_fire) begin
      resp_vld_d = 1'b1;
      resp_dat_d = mem[rd_row];
    end else if (rd_resp_ready) begin
      resp_vld_d = 1'b0;
    end
  end

  // Response register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_q       <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_dat_q <= '0;
    end else begin
      en_q       <= en_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
    end
  end

endmodule

// File: rtl/pspin_hostmem_dma_wr.sv
// AXI4 write slave that buffers one burst and hands it to a Corundum DMA write engine.
// Latency: descriptor the cycle after the last W beat; B the cycle after the write status.
// Backpressure: one burst outstanding; AW/W closed until B handshake; desc/B held until ready.
module pspin_hostmem_dma_wr
  import pspin_hostmem_dma_pkg::*;
#(
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_WIDTH         = 512,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 8,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int BUSER_WIDTH        = 1,
  parameter int DMA_IMM_WIDTH      = 32,
  parameter int DMA_LEN_WIDTH      = 16,
  parameter int DMA_TAG_WIDTH      = 16,
  parameter int RAM_SEL_WIDTH      = 4,
  parameter int RAM_ADDR_WIDTH     = 20,
  parameter int RAM_SEG_COUNT      = 2,
  parameter int RAM_SEG_DATA_WIDTH = 256,
  parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(DATA_WIDTH / 8),
  parameter int BUF_BEATS          = 16
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  output logic [ADDR_WIDTH-1:0]                      m_axis_write_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]                   m_axis_write_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]                  m_axis_write_desc_ram_addr,
  output logic [DMA_IMM_WIDTH-1:0]                   m_axis_write_desc_imm,
  output logic                                       m_axis_write_desc_imm_en,
  output logic [DMA_LEN_WIDTH-1:0]                   m_axis_write_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]                   m_axis_write_desc_tag,
  output logic                                       m_axis_write_desc_valid,
  input  logic                                       m_axis_write_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]                   s_axis_write_desc_status_tag,
  input  logic [3:0]                                 s_axis_write_desc_status_error,
  input  logic                                       s_axis_write_desc_status_valid,
  input  logic [RAM_SEG_COUNT*RAM_SEL_WIDTH-1:0]     ram_rd_cmd_sel,
  input  logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
  input  logic [RAM_SEG_COUNT-1:0]                   ram_rd_cmd_valid,
  output logic [RAM_SEG_COUNT-1:0]                   ram_rd_cmd_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
  output logic [RAM_SEG_COUNT-1:0]                   ram_rd_resp_valid,
  input  logic [RAM_SEG_COUNT-1:0]                   ram_rd_resp_ready,
  input  logic [ID_WIDTH-1:0]                        s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]                      s_axi_awaddr,
  input  logic [7:0]                                 s_axi_awlen,
  input  logic [2:0]                                 s_axi_awsize,
  input  logic [1:0]                                 s_axi_awburst,
  input  logic                                       s_axi_awlock,
  input  logic [3:0]                                 s_axi_awcache,
  input  logic [2:0]                                 s_axi_awprot,
  input  logic [3:0]                                 s_axi_awqos,
  input  logic [3:0]                                 s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0]                    s_axi_awuser,
  input  logic                                       s_axi_awvalid,
  output logic                                       s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                      s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]                      s_axi_wstrb,
  input  logic                                       s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]                     s_axi_wuser,
  input  logic                                       s_axi_wvalid,
  output logic                                       s_axi_wready,
  output logic [ID_WIDTH-1:0]                        s_axi_bid,
  output logic [1:0]                                 s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]                     s_axi_buser,
  output logic                                       s_axi_bvalid,
  input  logic                                       s_axi_bready
);

  localparam int IDX_W = $clog2(STRB_WIDTH);
  localparam int ROW_W = $clog2(BUF_BEATS);
  localparam int HI_W  = ADDR_WIDTH - IDX_W;

  // Byte index of the lowest set strobe; an empty strobe counts as starting at byte 0.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [STRB_WIDTH-1:0] s);
    lowest_set = '0;
    for (int i = STRB_WIDTH - 1; i >= 0; i--) begin
      if (s[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Byte index of the highest set strobe; an empty strobe counts as ending at the last byte.
  function automatic logic [IDX_W-1:0] highest_set(input logic [STRB_WIDTH-1:0] s);
    highest_set = IDX_W'(STRB_WIDTH - 1);
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (s[i]) highest_set = IDX_W'(i);
    end
  endfunction

  dma_state_e               state_q, state_d;
  logic [7:0]               beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [HI_W-1:0]          addr_hi_q, addr_hi_d;
  logic [7:0]               len_q, len_d;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         first_idx_q, first_idx_d;
  logic [IDX_W-1:0]         last_idx_q, last_idx_d;
  logic                     awready_q, awready_d;
  logic                     wready_q, wready_d;
  logic                     desc_vld_q, desc_vld_d;
  logic [ADDR_WIDTH-1:0]    desc_dma_addr_q, desc_dma_addr_d;
  logic [RAM_ADDR_WIDTH-1:0] desc_ram_addr_q, desc_ram_addr_d;
  logic [DMA_LEN_WIDTH-1:0] desc_len_q, desc_len_d;
  logic                     bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]      bid_q, bid_d;
  logic [1:0]               bresp_q, bresp_d;

  logic [IDX_W-1:0]         first_v, last_v;
  logic [DMA_LEN_WIDTH-1:0] span_v;
  logic                     buf_wr_en;
  logic [ROW_W-1:0]         buf_wr_row;
  logic                     unused_inputs;

  assign buf_wr_row = beat_cnt_q[ROW_W-1:0];

  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_awregion, s_axi_awuser, s_axi_wuser, ram_rd_cmd_sel,
                           s_axi_awaddr[IDX_W-1:0]};

  assign s_axi_awready              = awready_q;
  assign s_axi_wready               = wready_q;
  assign m_axis_write_desc_valid    = desc_vld_q;
  assign m_axis_write_desc_dma_addr = desc_dma_addr_q;
  assign m_axis_write_desc_ram_addr = desc_ram_addr_q;
  assign m_axis_write_desc_len      = desc_len_q;
  assign m_axis_write_desc_ram_sel  = '0;
  assign m_axis_write_desc_imm      = '0;
  assign m_axis_write_desc_imm_en   = 1'b0;
  assign m_axis_write_desc_tag      = '0;
  assign s_axi_bvalid               = bvalid_q;
  assign s_axi_bid                  = bid_q;
  assign s_axi_bresp                = bresp_q;
  assign s_axi_buser                = '0;

  // Next-state and registered-output logic for the single-burst FSM.
  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    id_d            = id_q;
    addr_hi_d       = addr_hi_q;
    len_d           = len_q;
    err_d           = err_q;
    first_idx_d     = first_idx_q;
    last_idx_d      = last_idx_q;
    awready_d       = awready_q;
    wready_d        = wready_q;
    desc_vld_d      = desc_vld_q;
    desc_dma_addr_d = desc_dma_addr_q;
    desc_ram_addr_d = desc_ram_addr_q;
    desc_len_d      = desc_len_q;
    bvalid_d        = bvalid_q;
    bid_d           = bid_q;
    bresp_d         = bresp_q;
    first_v         = first_idx_q;
    last_v          = last_idx_q;
    span_v          = '0;
    buf_wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          id_d        = s_axi_awid;
          addr_hi_d   = s_axi_awaddr[ADDR_WIDTH-1:IDX_W];
          len_d       = s_axi_awlen;
          err_d       = (s_axi_awburst != BURST_INCR) ||
                        (s_axi_awsize != 3'(IDX_W)) ||
                        (int'(s_axi_awlen) >= BUF_BEATS);
          beat_cnt_d  = '0;
          first_idx_d = '0;
          last_idx_d  = IDX_W'(STRB_WIDTH - 1);
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          state_d     = ST_DATA;
        end
      end

      ST_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          buf_wr_en  = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == 8'd0) begin
            first_v     = lowest_set(s_axi_wstrb);
            first_idx_d = first_v;
          end
          if (beat_cnt_q == len_q) begin
            last_v     = highest_set(s_axi_wstrb);
            last_idx_d = last_v;
          end
          span_v = (DMA_LEN_WIDTH'(len_q) << IDX_W) + DMA_LEN_WIDTH'(last_v)
                   + DMA_LEN_WIDTH'(1) - DMA_LEN_WIDTH'(first_v);
          if (s_axi_wlast || (beat_cnt_q == len_q)) begin
            wready_d = 1'b0;
            if (err_q) begin
              bvalid_d = 1'b1;
              bid_d    = id_q;
              bresp_d  = AXI_RESP_SLVERR;
              state_d  = ST_RESP;
            end else begin
              desc_vld_d      = 1'b1;
              desc_dma_addr_d = {addr_hi_q, {IDX_W{1'b0}}} + ADDR_WIDTH'(first_v);
              desc_ram_addr_d = RAM_ADDR_WIDTH'(first_v);
              desc_len_d      = span_v;
              state_d         = ST_DESC;
            end
          end
        end
      end

      ST_DESC: begin
        if (desc_vld_q && m_axis_write_desc_ready) begin
          desc_vld_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Status for other tags belongs to someone else sharing the engine.
        if (s_axis_write_desc_status_valid && (s_axis_write_desc_status_tag == '0)) begin
          bresp_d  = (s_axis_write_desc_status_error == 4'd0) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          bvalid_d = 1'b1;
          bid_d    = id_q;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      beat_cnt_q      <= '0;
      id_q            <= '0;
      addr_hi_q       <= '0;
      len_q           <= '0;
      err_q           <= 1'b0;
      first_idx_q     <= '0;
      last_idx_q      <= '0;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      desc_vld_q      <= 1'b0;
      desc_dma_addr_q <= '0;
      desc_ram_addr_q <= '0;
      desc_len_q      <= '0;
      bvalid_q        <= 1'b0;
      bid_q           <= '0;
      bresp_q         <= '0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      id_q            <= id_d;
      addr_hi_q       <= addr_hi_d;
      len_q           <= len_d;
      err_q           <= err_d;
      first_idx_q     <= first_idx_d;
      last_idx_q      <= last_idx_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      desc_vld_q      <= desc_vld_d;
      desc_dma_addr_q <= desc_dma_addr_d;
      desc_ram_addr_q <= desc_ram_addr_d;
      desc_len_q      <= desc_len_d;
      bvalid_q        <= bvalid_d;
      bid_q           <= bid_d;
      bresp_q         <= bresp_d;
    end
  end

  for (genvar s = 0; s < RAM_SEG_COUNT; s++) begin : g_seg
    pspin_hostmem_dma_seg_ram #(
      .DEPTH  (BUF_BEATS),
      .DATA_W (RAM_SEG_DATA_WIDTH),
      .ADDR_W (RAM_SEG_ADDR_WIDTH)
    ) u_ram (
      .clk           (clk),
      .rstn          (rstn),
      .wr_en         (buf_wr_en),
      .wr_row        (buf_wr_row),
      .wr_data       (s_axi_wdata[s*RAM_SEG_DATA_WIDTH +: RAM_SEG_DATA_WIDTH]),
      .rd_cmd_addr   (ram_rd_cmd_addr[s*RAM_SEG_ADDR_WIDTH +: RAM_SEG_ADDR_WIDTH]),
      .rd_cmd_valid  (ram_rd_cmd_valid[s]),
      .rd_cmd_ready  (ram_rd_cmd_ready[s]),
      .rd_resp_data  (ram_rd_resp_data[s*RAM_SEG_DATA_WIDTH +: RAM_SEG_DATA_WIDTH]),
      .rd_resp_valid (ram_rd_resp_valid[s]),
      .rd_resp_ready (ram_rd_resp_ready[s])
    );
  end

endmodule
